// File: rtl/mul_pkg.sv
// Shared defaults and FSM state encoding for the 16-bit multiplier issue controller.
package mul_pkg;

    localparam int unsigned MUL_LATENCY = 17;
    localparam int unsigned MUL_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_lat_cnt.sv
// Latency counter: counts edges spent in RUN and flags the edge that completes the wait.
module mul_lat_cnt
    import mul_pkg::*;
#(
    parameter int unsigned LATENCY = MUL_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    logic [CW-1:0] count;

    // Peak value is LATENCY, which always fits in CW bits, so it never wraps mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign done = enable && (count == LAST);

endmodule

// File: rtl/mul16_issue_ctrl.sv
// Issue controller for an external fixed-latency multiplier: holds operands stable for
// LATENCY edges, captures the product and hands it off with valid/ready on both sides.
module mul16_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned LATENCY = MUL_LATENCY,
    parameter int unsigned WIDTH   = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_en,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   lat_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In DONE a consumer take and a new accept can share one edge, going straight to RUN.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mul_en     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mul_en = 1'b1;
                busy   = 1'b1;
                if (lat_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                in_ready = rst_n && out_ready;
                busy     = 1'b1;
                if (out_ready) begin
                    state_next = accept ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    mul_lat_cnt #(
        .LATENCY (LATENCY)
    ) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (mul_en),
        .done   (lat_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            if (lat_done) begin
                out_p     <= mul_p;
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul16_issue_ctrl.sv
// Bench for mul16_issue_ctrl with a behavioural multiplier that only yields the product
// after LATENCY edges of stable, enabled operands, and an in-order result scoreboard.
module tb_mul16_issue_ctrl;

    localparam int unsigned LAT    = 17;
    localparam int unsigned W      = 16;
    localparam int unsigned N_RAND = 1500;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_en;
    logic [2*W-1:0] mul_p;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_p;
    logic           busy;

    int ntests = 0;
    int nfail  = 0;

    logic [2*W-1:0] sb[$];
    int             acq[$];
    int             cyc = 0;
    logic           ov_prev = 1'b0;

    logic           acc, xfer, rise;
    int             lat;
    logic [2*W-1:0] obs_p;
    logic [W-1:0]   obs_a, obs_b;
    logic           obs_en, obs_busy, obs_ov, obs_ir;

    mul16_issue_ctrl #(
        .LATENCY (LAT),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_en    (mul_en),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: garbage until operands have been stable and enabled long enough.
    int           stab = 0;
    logic [W-1:0] pa = '0;
    logic [W-1:0] pb = '0;

    always @(posedge clk) begin
        if (!mul_en)                        stab <= 0;
        else if (mul_a != pa || mul_b != pb) stab <= 1;
        else if (stab < LAT)                 stab <= stab + 1;
        pa <= mul_a;
        pb <= mul_b;
    end

    assign mul_p = (mul_en && stab >= LAT - 1) ? ((2*W)'(mul_a) * (2*W)'(mul_b)) : 32'hDEAD_BEEF;

    // One clock: drive, sample pre-edge, update scoreboard bookkeeping, advance.
    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        acc      = in_valid && in_ready;
        xfer     = out_valid && out_ready;
        rise     = out_valid && !ov_prev;
        obs_p    = out_p;
        obs_a    = mul_a;
        obs_b    = mul_b;
        obs_en   = mul_en;
        obs_busy = busy;
        obs_ov   = out_valid;
        obs_ir   = in_ready;
        lat      = (acq.size() > 0) ? (cyc - acq[0]) : -1;
        if (xfer && acq.size() > 0) void'(acq.pop_front());
        if (acc) begin
            sb.push_back((2*W)'(a) * (2*W)'(b));
            acq.push_back(cyc);
        end
        ov_prev = out_valid;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        ntests++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        ntests++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        ntests++; if (mul_en !== 1'b0) begin nfail++; $display("FAIL reset_mul_en got %b want 0", mul_en); end
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
        ntests++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin nfail++; $display("FAIL reset_mul_ab got %h/%h want 0/0", mul_a, mul_b); end
        ntests++; if (out_p !== 32'h0) begin nfail++; $display("FAIL reset_out_p got %h want 0", out_p); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        ov_prev  = 1'b0;
        #1;
        ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic_ops();
        logic [W-1:0]   ta [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        logic [W-1:0]   tbv[3] = '{16'hFFFF, 16'h1234, 16'hFFFF};
        logic [2*W-1:0] te [3] = '{32'hFFFE_0001, 32'h0000_0000, 32'h0000_FFFF};
        logic           stable, got;
        logic [2*W-1:0] want;
        for (int k = 0; k < 3; k++) begin
            stable = 1'b1;
            got    = 1'b0;
            cycle(1'b1, ta[k], tbv[k], 1'b1);
            ntests++; if (acc !== 1'b1) begin nfail++; $display("FAIL basic_accept[%0d] got %b want 1", k, acc); end
            for (int t = 0; t < 40 && !got; t++) begin
                cycle(1'b0, '0, '0, 1'b1);
                if (obs_busy && !obs_ov)
                    stable &= (obs_a === ta[k] && obs_b === tbv[k] && obs_en === 1'b1);
                if (rise) begin
                    ntests++; if (lat !== LAT + 1) begin nfail++; $display("FAIL basic_latency[%0d] got %0d want %0d", k, lat, LAT + 1); end
                end
                if (xfer) begin
                    got  = 1'b1;
                    want = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                    ntests++; if (obs_p !== want) begin nfail++; $display("FAIL basic_product[%0d] got %h want %h", k, obs_p, want); end
                    ntests++; if (obs_p !== te[k]) begin nfail++; $display("FAIL basic_literal[%0d] got %h want %h", k, obs_p, te[k]); end
                end
            end
            if (!got) begin ntests++; nfail++; $display("FAIL basic_timeout[%0d] got no result want one", k); end
            ntests++; if (stable !== 1'b1) begin nfail++; $display("FAIL basic_run_stable[%0d] got %b want 1", k, stable); end
            ntests++; if (busy !== 1'b0 || mul_en !== 1'b0) begin nfail++; $display("FAIL basic_idle[%0d] got busy=%b en=%b want 0/0", k, busy, mul_en); end
        end
    endtask

    task automatic test_backpressure();
        logic           got, hold_ok;
        logic [2*W-1:0] want;
        got     = 1'b0;
        hold_ok = 1'b1;
        cycle(1'b1, 16'h00AB, 16'h0102, 1'b0);
        for (int t = 0; t < 40 && !got; t++) begin
            cycle(1'b0, '0, '0, 1'b0);
            if (rise) begin
                got = 1'b1;
                ntests++; if (lat !== LAT + 1) begin nfail++; $display("FAIL bp_latency got %0d want %0d", lat, LAT + 1); end
            end
        end
        if (!got) begin ntests++; nfail++; $display("FAIL bp_timeout got no out_valid want one"); end
        want = 32'h00AB * 32'h0102;
        for (int t = 0; t < 10; t++) begin
            cycle(1'b1, 16'h7777, 16'h8888, 1'b0);
            hold_ok &= (obs_ov === 1'b1 && obs_ir === 1'b0 && obs_p === want && !acc && !xfer);
        end
        ntests++; if (hold_ok !== 1'b1) begin nfail++; $display("FAIL bp_hold got %b want 1", hold_ok); end
        cycle(1'b0, '0, '0, 1'b1);
        ntests++; if (xfer !== 1'b1) begin nfail++; $display("FAIL bp_release_xfer got %b want 1", xfer); end
        if (xfer) begin
            want = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
            ntests++; if (obs_p !== want) begin nfail++; $display("FAIL bp_product got %h want %h", obs_p, want); end
        end
        ntests++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nfail++; $display("FAIL bp_idle got busy=%b ov=%b ir=%b want 0/0/1", busy, out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   oa[2] = '{16'd3, 16'd7};
        logic [W-1:0]   ob[2] = '{16'd5, 16'd9};
        logic [2*W-1:0] oe[2] = '{32'd15, 32'd63};
        int             idx, k;
        logic           shared;
        logic [2*W-1:0] want;
        idx    = 0;
        k      = 0;
        shared = 1'b0;
        for (int t = 0; t < 80 && k < 2; t++) begin
            cycle(idx < 2, oa[idx % 2], ob[idx % 2], 1'b1);
            if (acc) idx++;
            if (rise) begin
                ntests++; if (lat !== LAT + 1) begin nfail++; $display("FAIL b2b_latency[%0d] got %0d want %0d", k, lat, LAT + 1); end
            end
            if (xfer) begin
                if (k == 0) shared = acc;
                want = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                ntests++; if (obs_p !== want || obs_p !== oe[k]) begin nfail++; $display("FAIL b2b_product[%0d] got %h want %h", k, obs_p, oe[k]); end
                k++;
            end
        end
        if (k < 2) begin ntests++; nfail++; $display("FAIL b2b_timeout got %0d results want 2", k); end
        ntests++; if (shared !== 1'b1) begin nfail++; $display("FAIL b2b_same_edge got %b want 1", shared); end
    endtask

    task automatic test_reset_mid_run();
        logic           spurious, got;
        logic [2*W-1:0] want;
        spurious = 1'b0;
        got      = 1'b0;
        cycle(1'b1, 16'h0055, 16'h0066, 1'b1);
        for (int t = 0; t < 8; t++) begin
            cycle(1'b0, '0, '0, 1'b1);
            spurious |= obs_ov;
        end
        rst_n = 1'b0;
        #1;
        ntests++; if (out_valid !== 1'b0 || busy !== 1'b0 || mul_en !== 1'b0 || in_ready !== 1'b0) begin
            nfail++; $display("FAIL midrun_reset got ov=%b busy=%b en=%b ir=%b want 0/0/0/0", out_valid, busy, mul_en, in_ready);
        end
        repeat (2) cycle(1'b1, 16'h0011, 16'h0022, 1'b1);
        rst_n = 1'b1;
        sb.delete();
        acq.delete();
        ov_prev = 1'b0;
        for (int t = 0; t < 30; t++) begin
            cycle(1'b0, '0, '0, 1'b1);
            spurious |= obs_ov;
        end
        ntests++; if (spurious !== 1'b0) begin nfail++; $display("FAIL midrun_discard got out_valid=%b want 0", spurious); end
        cycle(1'b1, 16'd2, 16'd3, 1'b1);
        for (int t = 0; t < 40 && !got; t++) begin
            cycle(1'b0, '0, '0, 1'b1);
            if (rise) begin
                ntests++; if (lat !== LAT + 1) begin nfail++; $display("FAIL midrun_next_latency got %0d want %0d", lat, LAT + 1); end
            end
            if (xfer) begin
                got  = 1'b1;
                want = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                ntests++; if (obs_p !== want || obs_p !== 32'd6) begin nfail++; $display("FAIL midrun_next_product got %h want 6", obs_p); end
            end
        end
        if (!got) begin ntests++; nfail++; $display("FAIL midrun_timeout got no result want one"); end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int             ndone;
        logic [W-1:0]   ca, cb;
        logic [2*W-1:0] want;
        ndone = 0;
        ca    = pick_operand();
        cb    = pick_operand();
        for (int t = 0; t < N_RAND * 60 && ndone < N_RAND; t++) begin
            cycle(1'($urandom_range(0, 1)), ca, cb, 1'($urandom_range(0, 3) != 0));
            if (acc) begin
                ca = pick_operand();
                cb = pick_operand();
            end
            if (rise) begin
                ntests++; if (lat !== LAT + 1) begin nfail++; $display("FAIL rand_latency[%0d] got %0d want %0d", ndone, lat, LAT + 1); end
            end
            if (xfer) begin
                want = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                ntests++; if (obs_p !== want) begin nfail++; $display("FAIL rand_product[%0d] got %h want %h", ndone, obs_p, want); end
                ndone++;
            end
        end
        if (ndone < N_RAND) begin ntests++; nfail++; $display("FAIL rand_timeout got %0d results want %0d", ndone, N_RAND); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_basic_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
